// File: rtl/bm_log_checker.sv
// Self-checking stimulus/response companion for the bitwise-logic microbenchmark: one LFSR operand pair per cycle, six results checked per vector.
// Latency: NUM_VECTORS+1 edges from start to done. No backpressure; the logic block is assumed to answer combinationally. Optional MISR via BM_LOG_MISR_EN.
module bm_log_checker #(
    parameter int          BITS        = 32,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'h0000_0001,
    parameter logic [31:0] POLY        = 32'h8020_0003
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    output logic [BITS-1:0] a,
    output logic [BITS-1:0] b,
    input  logic [BITS-1:0] r_and,
    input  logic [BITS-1:0] r_or,
    input  logic [BITS-1:0] r_xor,
    input  logic [BITS-1:0] r_xnor,
    input  logic [BITS-1:0] r_not,
    input  logic [BITS-1:0] r_mix,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     err_count,
    output logic [15:0]     first_err_idx
`ifdef BM_LOG_MISR_EN
    ,
    output logic [BITS-1:0] signature
`endif
);

    localparam logic [BITS-1:0] SEED_B   = BITS'(SEED);
    localparam logic [BITS-1:0] SEED_EFF = (SEED_B == '0) ? BITS'(1) : SEED_B;
    localparam logic [BITS-1:0] POLY_B   = BITS'(POLY);
    localparam logic [15:0]     LAST_IDX = 16'(NUM_VECTORS - 1);
    localparam int              HALF     = BITS / 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] lfsr_q;
    logic [BITS-1:0] lfsr_next;
    logic [15:0]     idx_q;
    logic            load;
    logic            check;
    logic            mismatch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    assign load  = start && (state_q != RUN);
    assign check = (state_q == RUN);

    // Right-shifting Galois step; POLY taps are XORed in when a one falls out of bit 0.
    assign lfsr_next = {1'b0, lfsr_q[BITS-1:1]} ^ (lfsr_q[0] ? POLY_B : '0);

    // One flag per vector, however many bits or results disagree.
    assign mismatch = (r_and  != (a & b))
                   || (r_or   != (a | b))
                   || (r_xor  != (a ^ b))
                   || (r_xnor != ~(a ^ b))
                   || (r_not  != ~a)
                   || (r_mix  != '1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q        <= SEED_EFF;
            a             <= '0;
            b             <= '0;
            idx_q         <= '0;
            err_count     <= '0;
            first_err_idx <= 16'hFFFF;
        end else if (load) begin
            lfsr_q        <= SEED_EFF;
            a             <= SEED_EFF;
            b             <= {SEED_EFF[HALF-1:0], SEED_EFF[BITS-1:HALF]};
            idx_q         <= '0;
            err_count     <= '0;
            first_err_idx <= 16'hFFFF;
        end else if (check) begin
            if (mismatch) begin
                if (err_count == '0)
                    first_err_idx <= idx_q;
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
            end
            // Operands freeze on the final vector so they stay observable in DONE.
            if (idx_q != LAST_IDX) begin
                lfsr_q <= lfsr_next;
                a      <= lfsr_next;
                b      <= {lfsr_next[HALF-1:0], lfsr_next[BITS-1:HALF]};
                idx_q  <= idx_q + 16'd1;
            end
        end
    end

`ifdef BM_LOG_MISR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            signature <= '0;
        end else if (load) begin
            signature <= '0;
        end else if (check) begin
            signature <= ({signature[BITS-2:0], signature[BITS-1]}
                          ^ (signature[BITS-1] ? POLY_B : '0))
                         ^ r_and ^ r_or ^ r_xor ^ r_xnor ^ r_not ^ r_mix;
        end
    end
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign pass = done && (err_count == '0);

endmodule
